// File: rtl/program_memory.sv
// Writable instruction store: self-clears after reset, serves 1-cycle fetches in RUN,
// and accepts MSB-first byte-serial program downloads in LOAD.
module program_memory #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 64,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iReadEnable,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oBusy,
    input  logic                  iLoadStart,
    input  logic                  iLoadDone,
    input  logic                  iLoadValid,
    input  logic [7:0]            iLoadByte,
    output logic                  oLoadReady,
    output logic [ADDR_WIDTH-1:0] oLoadCount,
    output logic                  oLoadFull,
    output logic [1:0]            oState
);

    localparam int BPW    = (DATA_WIDTH + 7) / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BCW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HIST_W = DATA_WIDTH - 8;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);

    // Handshake: a download byte transfers on a rising edge where iLoadValid and
    // oLoadReady are both high; iLoadStart/iLoadDone in that cycle take priority
    // and the byte is dropped.
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      init_ptr;
    logic [IDX_W-1:0]      wr_ptr;
    logic [BCW-1:0]        byte_cnt;
    logic [HIST_W-1:0]     asm_q;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  accept;
    logic                  word_done;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign oState = state;

    // Older bytes shift toward the top; excess bits of the first byte fall off.
    assign asm_word  = {asm_q, iLoadByte};
    assign accept    = (state == S_LOAD) && oLoadReady && iLoadValid && !iLoadStart && !iLoadDone;
    assign word_done = accept && (byte_cnt == LAST_BYTE);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_ptr;
        mem_wdata = DEFAULT_WORD;
        if (!Reset) begin
            if (state == S_INIT) begin
                mem_we = 1'b1;
            end else if (word_done) begin
                mem_we    = 1'b1;
                mem_waddr = wr_ptr;
                mem_wdata = asm_word;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_INIT;
            init_ptr     <= '0;
            wr_ptr       <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            oInstruction <= DEFAULT_WORD;
            oBusy        <= 1'b1;
            oLoadReady   <= 1'b0;
            oLoadCount   <= '0;
            oLoadFull    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    oInstruction <= DEFAULT_WORD;
                    init_ptr     <= init_ptr + 1'b1;
                    if (init_ptr == LAST_IDX) begin
                        state <= S_RUN;
                        oBusy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (iReadEnable)
                        oInstruction <= ({1'b0, iAddress} < DEPTH_LIM) ?
                                        mem[iAddress[IDX_W-1:0]] : DEFAULT_WORD;
                    if (iLoadStart) begin
                        state      <= S_LOAD;
                        oBusy      <= 1'b1;
                        oLoadReady <= 1'b1;
                        wr_ptr     <= '0;
                        byte_cnt   <= '0;
                        oLoadCount <= '0;
                        oLoadFull  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    oInstruction <= DEFAULT_WORD;
                    if (iLoadStart) begin
                        wr_ptr     <= '0;
                        byte_cnt   <= '0;
                        oLoadCount <= '0;
                    end else if (iLoadDone) begin
                        state      <= S_RUN;
                        oBusy      <= 1'b0;
                        oLoadReady <= 1'b0;
                        byte_cnt   <= '0;
                    end else if (accept) begin
                        asm_q <= asm_word[HIST_W-1:0];
                        if (word_done) begin
                            byte_cnt   <= '0;
                            wr_ptr     <= wr_ptr + 1'b1;
                            oLoadCount <= oLoadCount + 1'b1;
                            if (wr_ptr == LAST_IDX) begin
                                oLoadFull  <= 1'b1;
                                state      <= S_RUN;
                                oBusy      <= 1'b0;
                                oLoadReady <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_INIT;
                    oBusy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Randomised bench for program_memory: a byte-list program model feeds a fetch
// scoreboard, plus direct status checks around init, loads and resets.
module tb_program_memory;

    localparam int              DW    = 28;
    localparam int              AW    = 16;
    localparam int              DEPTH = 64;
    localparam logic [DW-1:0]   DEF   = 28'hA5C3E71;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] iAddress = '0;
    logic          iReadEnable = 1'b0;
    logic [DW-1:0] oInstruction;
    logic          oBusy;
    logic          iLoadStart = 1'b0;
    logic          iLoadDone = 1'b0;
    logic          iLoadValid = 1'b0;
    logic [7:0]    iLoadByte = '0;
    logic          oLoadReady;
    logic [AW-1:0] oLoadCount;
    logic          oLoadFull;
    logic [1:0]    oState;

    program_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DEFAULT_WORD(DEF)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iReadEnable(iReadEnable),
        .oInstruction(oInstruction), .oBusy(oBusy), .iLoadStart(iLoadStart),
        .iLoadDone(iLoadDone), .iLoadValid(iLoadValid), .iLoadByte(iLoadByte),
        .oLoadReady(oLoadReady), .oLoadCount(oLoadCount), .oLoadFull(oLoadFull),
        .oState(oState)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    logic [7:0]    part_q[$];
    int            model_wptr = 0;
    int            model_count = 0;
    bit            model_full = 0;
    bit            model_loading = 0;

    function automatic logic [DW-1:0] model_fetch(input int a);
        if (model_loading || a >= DEPTH) return DEF;
        return model_mem[a];
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (!model_loading) return;
        part_q.push_back(b);
        if (part_q.size() == 4) begin
            w = {part_q[0], part_q[1], part_q[2], part_q[3]};
            model_mem[model_wptr] = w[DW-1:0];
            model_wptr++;
            model_count++;
            part_q.delete();
            if (model_wptr == DEPTH) begin
                model_full    = 1;
                model_loading = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          chk_pending = 1'b0;

    always @(posedge Clock) chk_pending <= iReadEnable;

    always @(negedge Clock) begin
        if (chk_pending) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("fetch", oInstruction, exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic fetch_exp(input int a, input logic [DW-1:0] e);
        iAddress    = AW'(a);
        iReadEnable = 1'b1;
        exp_q.push_back(e);
        @(negedge Clock);
        iReadEnable = 1'b0;
    endtask

    task automatic fetch(input int a);
        fetch_exp(a, model_fetch(a));
    endtask

    task automatic fetch_all();
        for (int a = 0; a < DEPTH; a++) fetch(a);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DEF;
        part_q.delete();
        model_wptr = 0; model_count = 0; model_full = 0; model_loading = 0;
        check("rst_instr", oInstruction, DEF);
        check("rst_busy", oBusy, 1);
        check("rst_ready", oLoadReady, 0);
        check("rst_count", oLoadCount, 0);
        check("rst_full", oLoadFull, 0);
    endtask

    task automatic wait_init(input bit poke);
        int cnt = 0;
        while (oBusy && cnt < 200) begin
            iLoadStart = poke && (cnt == 5);
            @(negedge Clock);
            cnt++;
        end
        iLoadStart = 1'b0;
        check("busy_len", cnt, DEPTH);
    endtask

    task automatic check_status(input string name);
        check({name, "_ready"}, oLoadReady, model_loading);
        check({name, "_busy"}, oBusy, model_loading);
        check({name, "_count"}, oLoadCount, model_count);
        check({name, "_full"}, oLoadFull, model_full);
    endtask

    task automatic load_start();
        iLoadStart = 1'b1;
        @(negedge Clock);
        iLoadStart = 1'b0;
        part_q.delete();
        model_wptr = 0; model_count = 0; model_full = 0; model_loading = 1;
    endtask

    task automatic load_done();
        iLoadDone = 1'b1;
        @(negedge Clock);
        iLoadDone = 1'b0;
        part_q.delete();
        model_loading = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) @(negedge Clock);
        iLoadValid = 1'b1;
        iLoadByte  = b;
        @(negedge Clock);
        iLoadValid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset clear
        do_reset();
        wait_init(0);
        check_status("post_init");
        fetch_all();
        fetch(100);
        fetch(DEPTH);

        // Single-word load
        load_start();
        check_status("start");
        send_byte(8'hFF); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        load_done();
        check_status("single");
        fetch_exp(0, 28'hF234567);
        fetch(1);

        // Partial-word discard
        load_start();
        send_rand(6);
        load_done();
        check_status("partial");
        fetch(0); fetch(1); fetch(2);

        // Byte coinciding with iLoadDone is dropped
        load_start();
        send_rand(3);
        iLoadValid = 1'b1; iLoadByte = 8'h5A; iLoadDone = 1'b1;
        @(negedge Clock);
        iLoadValid = 1'b0; iLoadDone = 1'b0;
        part_q.delete(); model_loading = 0;
        check_status("byte_done");
        fetch(0);

        // Fetch during LOAD, then simultaneous start+done (start wins)
        load_start();
        fetch(0);
        iLoadStart = 1'b1; iLoadDone = 1'b1;
        @(negedge Clock);
        iLoadStart = 1'b0; iLoadDone = 1'b0;
        part_q.delete(); model_wptr = 0; model_count = 0;
        check_status("start_wins");
        load_done();

        // Full memory
        load_start();
        send_rand(4 * DEPTH);
        check_status("full");
        send_byte(8'hC3);
        check_status("byte257");
        fetch_all();

        // Stall then restart
        fetch(5);
        for (int i = 0; i < 3; i++) begin
            iAddress = AW'($urandom_range(0, DEPTH - 1));
            @(negedge Clock);
            check("stall_hold", oInstruction, model_fetch(5));
        end
        load_start();
        send_rand(2);
        load_start();
        send_rand(4);
        load_done();
        check_status("restart");
        fetch(0); fetch(1);

        // Reset mid-load, with an ignored iLoadStart during INIT
        load_start();
        send_rand(10);
        check("midload_count", oLoadCount, 2);
        do_reset();
        wait_init(1);
        check_status("reinit");
        fetch_all();

        repeat (3) @(negedge Clock);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, writable instruction store for the VGA soft processor. It replaces the hard-coded case-statement ROM in front of the fetch stage. A synchronous read port serves the processor. A byte-serial load port lets a host (UART bridge) download a new program without resynthesis. After reset the block self-clears every location to a default word before releasing the processor.

## Interface
- DATA_WIDTH, 28 — instruction word width.
- ADDR_WIDTH, 16 — width of the fetch address and of the load counter.
- DEPTH, 64 — number of stored words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- DEFAULT_WORD, 28'd0 — word returned for cleared, out-of-range or busy fetches. Integration overrides it with the LED-pattern trap instruction.
- Clock  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- iAddress  in  ADDR_WIDTH  fetch address.
- iReadEnable  in  1  fetch strobe; low holds oInstruction (stall).
- oInstruction  out  DATA_WIDTH  registered fetched word.
- oBusy  out  1  high in INIT or LOAD; the processor must hold its PC while high.
- iLoadStart  in  1  single-cycle pulse that opens a download.
- iLoadDone  in  1  single-cycle pulse that closes a download.
- iLoadValid  in  1  iLoadByte is valid this cycle.
- iLoadByte  in  8  download byte.
- oLoadReady  out  1  high in LOAD state; a byte is accepted when iLoadValid and oLoadReady are both high.
- oLoadCount  out  ADDR_WIDTH  number of complete words written in the current or most recent download.
- oLoadFull  out  1  sticky; set when location DEPTH-1 is written by a download.

## Operation
- BPW = ceil(DATA_WIDTH/8) bytes per word; 4 at the defaults.
- Bytes arrive MSB-first. The first byte of a word contributes only its low DATA_WIDTH-8*(BPW-1) bits; the excess high bits are ignored.
- **INIT** (entered on Reset)
  - One location per cycle, ascending from 0, is written with DEFAULT_WORD; DEPTH cycles total.
  - Then go to RUN.
  - iLoadStart is ignored in INIT.
- **RUN**
  - On iReadEnable: oInstruction ← mem[iAddress] if iAddress < DEPTH, else DEFAULT_WORD.
  - iLoadStart → LOAD. On entry: write pointer, byte counter and oLoadCount cleared; oLoadFull cleared.
- **LOAD**
  - Each accepted byte shifts into the assembly register.
  - When the BPW-th byte is accepted, the word is written at the pointer in that same cycle. The pointer and oLoadCount then increment.
  - Writing location DEPTH-1: set oLoadFull and go to RUN.
  - iLoadDone → RUN; a partial word is discarded.
  - iLoadStart in LOAD restarts the download: pointer, byte counter and count cleared; the partial word is discarded; memory is not cleared.
  - If iLoadStart and iLoadDone are high in the same cycle, iLoadStart wins.
  - A byte accepted in the same cycle as iLoadDone is discarded.
  - Locations not rewritten keep their previous contents.
- **During INIT and LOAD**: oInstruction ← DEFAULT_WORD on every cycle, regardless of iReadEnable.
- Reset at any time, including mid-load: go to INIT and re-clear all memory.

## Timing
- Reset values:
  - oInstruction = DEFAULT_WORD
  - oBusy = 1
  - oLoadReady = 0
  - oLoadCount = 0
  - oLoadFull = 0
- Read latency is 1 cycle: the address presented at edge N appears on oInstruction after edge N+1.
- oBusy falls on the edge that writes location DEPTH-1 in INIT; the first valid fetch is requested on the next edge.
- Write-then-read: a fetch in the cycle after a word is written returns the new value. No same-cycle bypass is required, because the processor is stalled during LOAD.
- oLoadReady rises the cycle after iLoadStart is sampled. It falls on the edge that leaves LOAD.
- Memory is inferred as a single-port synchronous RAM: one write or one read per cycle.

## Test plan
- **Reset clear**: assert Reset for 1 cycle, wait. Required: oBusy high for exactly 64 cycles. Then every fetch of addresses 0..63 returns DEFAULT_WORD. A fetch of address 100 returns DEFAULT_WORD.
- **Single-word load**: iLoadStart, then bytes 0xFF,0x23,0x45,0x67, then iLoadDone. Required: oLoadCount = 1; fetch of address 0 returns 28'hF234567; address 1 is unchanged.
- **Partial-word discard**: load 6 bytes, then iLoadDone. Required: oLoadCount = 1; address 1 still holds DEFAULT_WORD.
- **Full memory**: stream 256 bytes. Required: oLoadFull = 1; oLoadReady drops after the 256th byte; byte 257 is ignored; oLoadCount = 64.
- **Stall and restart**: hold iReadEnable low for 3 cycles; oInstruction is held. Issue iLoadStart after 2 bytes of a load; the next 4 bytes land at address 0.
- **Reset mid-load**: assert Reset after 2 of 5 words are written. Required: INIT reruns and all 64 locations read DEFAULT_WORD afterwards.
